// File: rtl/gcd_core_if.sv
// Start/done handshake bundle between a controller and the GCD engine.
// The controller side drives the launch request and operands; the engine side
// returns status and the registered answer.
interface gcd_core_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] iterations;

  modport master (
    output start, a, b,
    input  busy, done, result, iterations
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, iterations
  );
endinterface

// File: rtl/gcd_core.sv
// Sequential GCD engine using Euclid's subtraction algorithm.
// One compare-or-subtract step per cycle in CALC; a single-cycle DONE state
// produces the done pulse. result and iterations are registered and held
// until the next accepted start so a display stage can read them at leisure.
module gcd_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  gcd_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] x, x_next;
  logic [WIDTH-1:0] y, y_next;
  logic [WIDTH-1:0] result, result_next;
  logic [WIDTH-1:0] iter, iter_next;
  logic [WIDTH-1:0] iter_inc;

  // Step counter that sticks at all-ones instead of wrapping.
  assign iter_inc = (iter == '1) ? iter : iter + 1'b1;

  // State and datapath registers; reset is synchronous and overrides start.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order inside the block.
    if (reset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      result <= '0;
      iter   <= '0;
    end else begin
      state  <= state_next;
      x      <= x_next;
      y      <= y_next;
      result <= result_next;
      iter   <= iter_next;
    end
  end

  // Next-state, datapath update and status outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next  = state;
    x_next      = x;
    y_next      = y;
    result_next = result;
    iter_next   = iter;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          x_next     = bus.a;
          y_next     = bus.b;
          iter_next  = '0;
          state_next = CALC;
        end
      end

      CALC: begin
        bus.busy = 1'b1;
        if (x == '0) begin
          result_next = y;
          state_next  = DONE;
        end else if (y == '0) begin
          result_next = x;
          state_next  = DONE;
        end else if (x == y) begin
          result_next = x;
          state_next  = DONE;
        end else if (x > y) begin
          // Only the larger operand is reduced, so no underflow is possible.
          x_next    = x - y;
          iter_next = iter_inc;
        end else begin
          y_next    = y - x;
          iter_next = iter_inc;
        end
      end

      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.result     = result;
  assign bus.iterations = iter;

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed scenarios plus randomized
// operands, each compared against a modulo-based Euclid reference model.
module tb_gcd_core;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gcd_core_if #(.WIDTH(W)) gif ();

  gcd_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference GCD by repeated remainder.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtraction steps: each remainder step stands for q subtractions,
  // except the final one, which stops one short at equality.
  function automatic int ref_steps(input int a, input int b);
    int s, t;
    if (a == 0 || b == 0) return 0;
    s = 0;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s - 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one computation from IDLE and check everything up to the cycle
  // after the done pulse. poke_mid re-pulses start (a=10, b=4) during CALC.
  task automatic run(input int va, input int vb, input bit poke_mid, input string tag);
    int         exp_r, exp_it, cyc, busy_cnt;
    logic [W-1:0] prev;
    bit         hold_ok;
    exp_r    = ref_gcd(va, vb);
    exp_it   = ref_steps(va, vb);
    prev     = gif.result;
    gif.a     = W'(va);
    gif.b     = W'(vb);
    gif.start = 1'b1;
    tick;
    gif.start = 1'b0;
    gif.a     = W'($urandom);
    gif.b     = W'($urandom);
    cyc      = 1;
    busy_cnt = 0;
    hold_ok  = 1'b1;
    while (gif.done !== 1'b1 && cyc < 400) begin
      if (gif.busy === 1'b1) busy_cnt++;
      if (gif.result !== prev) hold_ok = 1'b0;
      if (poke_mid && cyc == 3) begin
        gif.a     = 8'd10;
        gif.b     = 8'd4;
        gif.start = 1'b1;
      end else begin
        gif.start = 1'b0;
      end
      tick;
      cyc++;
    end
    gif.start = 1'b0;
    check({tag, " done_seen"}, gif.done, 1);
    check({tag, " latency"}, cyc, exp_it + 2);
    check({tag, " busy_cycles"}, busy_cnt, exp_it + 1);
    check({tag, " result"}, gif.result, exp_r);
    check({tag, " iterations"}, gif.iterations, (exp_it > 255) ? 255 : exp_it);
    check({tag, " busy_at_done"}, gif.busy, 0);
    check({tag, " result_held"}, hold_ok, 1);
    tick;
    check({tag, " done_one_cycle"}, gif.done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r;
    bit  seen;
    reset     = 1'b1;
    gif.start = 1'b0;
    gif.a     = '0;
    gif.b     = '0;
    tick;
    tick;
    check("reset busy", gif.busy, 0);
    check("reset done", gif.done, 0);
    check("reset result", gif.result, 0);
    check("reset iterations", gif.iterations, 0);
    reset = 1'b0;
    tick;

    run(48, 18, 1'b0, "48_18");
    run(255, 1, 1'b0, "255_1");
    r = int'(gif.result);
    check("bcd tens", (r / 10) % 10, 0);
    check("bcd ones", r % 10, 1);

    run(0, 37, 1'b0, "0_37");
    run(37, 0, 1'b0, "37_0");
    run(0, 0, 1'b0, "0_0");

    run(91, 65, 1'b1, "hs_91_65");
    check("hs idle result", gif.result, 13);
    check("hs idle busy", gif.busy, 0);
    run(10, 4, 1'b0, "hs_10_4");

    // Reset on the 10th CALC cycle, with start also high: reset wins.
    gif.a     = 8'd200;
    gif.b     = 8'd3;
    gif.start = 1'b1;
    tick;
    gif.start = 1'b0;
    repeat (9) tick;
    check("midrst busy_before", gif.busy, 1);
    reset     = 1'b1;
    gif.start = 1'b1;
    tick;
    check("midrst busy", gif.busy, 0);
    check("midrst done", gif.done, 0);
    check("midrst result", gif.result, 0);
    check("midrst iterations", gif.iterations, 0);
    reset     = 1'b0;
    gif.start = 1'b0;
    seen      = 1'b0;
    repeat (80) begin
      if (gif.done === 1'b1 || gif.busy === 1'b1) seen = 1'b1;
      tick;
    end
    check("midrst no_activity", seen, 0);

    run(77, 77, 1'b0, "77_77");

    // start held high: accept, CALC, DONE, repeat -> done every 3rd cycle.
    gif.a     = 8'd77;
    gif.b     = 8'd77;
    gif.start = 1'b1;
    tick;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("b2b done k%0d", k), gif.done, (k % 3 == 2) ? 1 : 0);
      if (k % 3 == 2) check($sformatf("b2b result k%0d", k), gif.result, 77);
      tick;
    end
    gif.start = 1'b0;
    repeat (3) tick;
    check("b2b idle busy", gif.busy, 0);

    for (int i = 0; i < 12; i++) begin
      int ra, rb;
      if (i % 3 == 0) begin
        ra = $urandom_range(0, 15);
        rb = $urandom_range(0, 15);
      end else begin
        ra = $urandom_range(0, 255);
        rb = $urandom_range(0, 255);
      end
      run(ra, rb, 1'b0, $sformatf("rnd%0d_%0d_%0d", i, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_core.md
Name: gcd_core

Overview:
- Sequential GCD engine using Euclid's subtraction algorithm on two unsigned operands.
- Sits directly upstream of the binary-to-BCD display stage: its `result` bus drives that stage's 8-bit binary input.
- Uses a start/done handshake, so a top-level controller (switches/button) can launch a computation and latch the answer for display.

Parameters:
- WIDTH, 8, operand/result width in bits. The downstream display stage requires 8.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the edge where start is accepted
- b  input  WIDTH  operand B; sampled on the edge where start is accepted
- busy  output  1  high while a computation is in progress (state CALC)
- done  output  1  one-cycle pulse; result is valid from this cycle on
- result  output  WIDTH  GCD of last accepted operands; held until next accepted start
- iterations  output  WIDTH  number of subtraction steps performed, saturating at all-ones

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on the rising edge of clk; no asynchronous path.
- Reset values: state=IDLE, busy=0, done=0, result=0, iterations=0, internal x=y=0.
- States:
  - IDLE:
    - start=1 -> x<=a, y<=b, iterations<=0, go CALC. result keeps its old value.
    - start=0 -> stay in IDLE.
  - CALC (busy=1), one evaluation per cycle, in this priority:
    - x==0 -> result<=y, go DONE.
    - y==0 -> result<=x, go DONE.
    - x==y -> result<=x, go DONE.
    - x>y -> x<=x-y, iterations+1.
    - otherwise -> y<=y-x, iterations+1.
  - DONE: done=1, busy=0 for exactly one cycle; unconditionally return to IDLE.
- Subtraction: only the larger value is decremented by the smaller, so results never underflow. All arithmetic is unsigned, WIDTH bits.
- iterations saturates at 2^WIDTH-1 and never wraps. For WIDTH=8 the true maximum is 254, so saturation is unreachable but still required.
- Latency from the start-accept edge to the first done cycle is (number of subtractions + 2) cycles.
- start is ignored in CALC and DONE; no queuing. A start held high in IDLE after DONE launches a new computation with the current a/b.
- Operands may change freely after the accept edge; the computation uses the latched x/y.
- result and iterations are registered outputs. They are stable in every state except on the terminating CALC edge and the subtraction edges (iterations).
- Reset asserted mid-CALC or in DONE: next edge forces IDLE and clears all outputs. No done pulse is emitted for the aborted run.
- Reset and start high on the same edge: reset wins.

Test Plan:
- reset, then a=48, b=18, start pulse:
  - busy high for 5 cycles, then done pulse.
  - result=6, iterations=4.
  - done asserted exactly 6 cycles after the accept edge.
- a=255, b=1:
  - result=1, iterations=254, busy high for 255 cycles.
  - Feeding result into the BCD stage shows tens=0, ones=1.
- Zero operands:
  - a=0, b=37 -> result=37, iterations=0.
  - a=37, b=0 -> result=37, iterations=0.
  - a=0, b=0 -> result=0, iterations=0.
  - Each of these gives done 2 cycles after accept.
- Handshake:
  - a=91, b=65 -> result=13.
  - Pulse start again mid-CALC with a=10, b=4: ignored; result still 13.
  - After done, start with a=10, b=4 -> result=2.
  - Result holds 13 until the second run's terminating edge.
- Reset mid-run: start a=200, b=3, assert reset on the 10th CALC cycle -> next cycle busy=0, done=0, result=0, iterations=0, and no done pulse.
- Equal operands: a=b=77 -> result=77, iterations=0. Then start held high continuously -> back-to-back runs, with a done pulse every 3 cycles.
